// File: rtl/connect4_move_sequencer.sv
// Connect4 move sequencer: accepts a column request, writes the piece to the board RAM,
// runs the external win check and advances turn, move count and game status.
module connect4_move_sequencer #(
  parameter int unsigned COLS          = 7,
  parameter int unsigned ROWS          = 6,
  parameter int unsigned CHECK_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       new_game_i,
  input  logic       move_valid_i,
  input  logic [2:0] move_col_i,
  output logic       move_ready_o,
  output logic       illegal_move_o,
  output logic       board_we_o,
  output logic [2:0] board_row_o,
  output logic [2:0] board_col_o,
  output logic [1:0] board_piece_o,
  output logic       check_start_o,
  input  logic       check_done_i,
  input  logic       check_win_i,
  output logic       check_timeout_o,
  output logic       player_turn_o,
  output logic [1:0] game_status_o,
  output logic [5:0] move_count_o
);

  localparam int unsigned Cells = ROWS * COLS;
  localparam int unsigned TmoW  = $clog2(CHECK_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StWrite, StCheck, StWait, StOver} state_e;

  state_e          state_q, state_d;
  logic [2:0]      height_q [COLS];
  logic [2:0]      height_d [COLS];
  logic [5:0]      move_count_q, move_count_d;
  logic            player_turn_q, player_turn_d;
  logic [1:0]      game_status_q, game_status_d;
  logic [2:0]      col_q, col_d;
  logic [2:0]      row_q, row_d;
  logic            illegal_q, illegal_d;
  logic [TmoW-1:0] wait_cnt_q, wait_cnt_d;

  logic [2:0] req_height;
  logic       req_legal;
  logic       clear_game;
  logic       timeout;
  logic       win;

  // Guarded lookup so an out-of-range column never indexes past the array.
  always_comb begin
    req_height = '0;
    for (int i = 0; i < COLS; i++) begin
      if (move_col_i == 3'(i)) req_height = height_q[i];
    end
    req_legal = (32'(move_col_i) < COLS) && (32'(req_height) < ROWS);
  end

  assign clear_game = new_game_i && ((state_q == StIdle) || (state_q == StOver));
  assign timeout    = (wait_cnt_q == TmoW'(CHECK_TIMEOUT));

  always_comb begin
    state_d         = state_q;
    height_d        = height_q;
    move_count_d    = move_count_q;
    player_turn_d   = player_turn_q;
    game_status_d   = game_status_q;
    col_d           = col_q;
    row_d           = row_q;
    illegal_d       = 1'b0;
    wait_cnt_d      = wait_cnt_q;
    win             = 1'b0;
    move_ready_o    = 1'b0;
    board_we_o      = 1'b0;
    board_row_o     = '0;
    board_col_o     = '0;
    board_piece_o   = '0;
    check_start_o   = 1'b0;
    check_timeout_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        move_ready_o = 1'b1;
        if (move_valid_i) begin
          if (req_legal) begin
            col_d   = move_col_i;
            row_d   = req_height;
            state_d = StWrite;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StWrite: begin
        board_we_o    = 1'b1;
        board_row_o   = row_q;
        board_col_o   = col_q;
        board_piece_o = {player_turn_q, ~player_turn_q};
        for (int i = 0; i < COLS; i++) begin
          if (col_q == 3'(i)) height_d[i] = height_q[i] + 3'd1;
        end
        move_count_d = move_count_q + 6'd1;
        state_d      = StCheck;
      end
      StCheck: begin
        check_start_o = 1'b1;
        board_row_o   = row_q;
        board_col_o   = col_q;
        wait_cnt_d    = '0;
        state_d       = StWait;
      end
      StWait: begin
        if (check_done_i || timeout) begin
          // A timed-out check counts as "no win"; a real done wins the tie.
          check_timeout_o = !check_done_i;
          win             = check_done_i && check_win_i;
          if (win) begin
            game_status_d = player_turn_q ? 2'b10 : 2'b01;
            state_d       = StOver;
          end else if (32'(move_count_q) == Cells) begin
            game_status_d = 2'b11;
            state_d       = StOver;
          end else begin
            player_turn_d = ~player_turn_q;
            state_d       = StIdle;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + TmoW'(1);
        end
      end
      StOver: begin
        state_d = StOver;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clear_game) begin
      state_d       = StIdle;
      for (int i = 0; i < COLS; i++) height_d[i] = '0;
      move_count_d  = '0;
      player_turn_d = 1'b0;
      game_status_d = '0;
      col_d         = '0;
      row_d         = '0;
      illegal_d     = 1'b0;
      wait_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      for (int i = 0; i < COLS; i++) height_q[i] <= '0;
      move_count_q  <= '0;
      player_turn_q <= 1'b0;
      game_status_q <= '0;
      col_q         <= '0;
      row_q         <= '0;
      illegal_q     <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      height_q      <= height_d;
      move_count_q  <= move_count_d;
      player_turn_q <= player_turn_d;
      game_status_q <= game_status_d;
      col_q         <= col_d;
      row_q         <= row_d;
      illegal_q     <= illegal_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign illegal_move_o = illegal_q;
  assign player_turn_o  = player_turn_q;
  assign game_status_o  = game_status_q;
  assign move_count_o   = move_count_q;

endmodule

// File: tb/tb_connect4_move_sequencer.sv
// Directed bench for connect4_move_sequencer: expected board writes are queued when a move
// is issued and compared by a monitor when board_we fires.
module tb_connect4_move_sequencer;

  logic       clk = 1'b0;
  logic       reset, new_game, move_valid, check_done, check_win;
  logic [2:0] move_col;
  logic       move_ready, illegal_move, board_we, check_start, check_timeout, player_turn;
  logic [2:0] board_row, board_col;
  logic [1:0] board_piece, game_status;
  logic [5:0] move_count;

  always #5 clk = ~clk;

  connect4_move_sequencer #(
    .COLS         (7),
    .ROWS         (6),
    .CHECK_TIMEOUT(16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .new_game_i     (new_game),
    .move_valid_i   (move_valid),
    .move_col_i     (move_col),
    .move_ready_o   (move_ready),
    .illegal_move_o (illegal_move),
    .board_we_o     (board_we),
    .board_row_o    (board_row),
    .board_col_o    (board_col),
    .board_piece_o  (board_piece),
    .check_start_o  (check_start),
    .check_done_i   (check_done),
    .check_win_i    (check_win),
    .check_timeout_o(check_timeout),
    .player_turn_o  (player_turn),
    .game_status_o  (game_status),
    .move_count_o   (move_count)
  );

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] piece;
  } wr_t;

  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];
  int   mh[8];
  logic mturn;
  int   mcount;
  logic [1:0] mstatus;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (board_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(board_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_row", 32'(board_row), 32'(e.row));
        chk("wr_col", 32'(board_col), 32'(e.col));
        chk("wr_piece", 32'(board_piece), 32'(e.piece));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mh[i] = 0;
    mturn   = 1'b0;
    mcount  = 0;
    mstatus = 2'b00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(move_ready), 32'd1);
    chk({tag, "_illegal"}, 32'(illegal_move), 32'd0);
    chk({tag, "_we"}, 32'(board_we), 32'd0);
    chk({tag, "_row"}, 32'(board_row), 32'd0);
    chk({tag, "_col"}, 32'(board_col), 32'd0);
    chk({tag, "_piece"}, 32'(board_piece), 32'd0);
    chk({tag, "_start"}, 32'(check_start), 32'd0);
    chk({tag, "_timeout"}, 32'(check_timeout), 32'd0);
    chk({tag, "_turn"}, 32'(player_turn), 32'd0);
    chk({tag, "_status"}, 32'(game_status), 32'd0);
    chk({tag, "_count"}, 32'(move_count), 32'd0);
  endtask

  task automatic push_expected(input int col);
    wr_t w;
    w.row   = 3'(mh[col]);
    w.col   = 3'(col);
    w.piece = {mturn, ~mturn};
    exp_q.push_back(w);
  endtask

  // Issue one legal move and drive the checker after dly WAIT cycles.
  task automatic play(input int col, input bit win, input int dly);
    push_expected(col);
    chk("ready_before", 32'(move_ready), 32'd1);
    move_valid = 1'b1;
    move_col   = 3'(col);
    tick();
    move_valid = 1'b0;
    chk("we_latency", 32'(board_we), 32'd1);
    tick();
    chk("start_latency", 32'(check_start), 32'd1);
    chk("hold_row", 32'(board_row), 32'(mh[col]));
    chk("hold_col", 32'(board_col), 32'(col));
    mh[col]++;
    mcount++;
    tick();
    chk("ready_wait", 32'(move_ready), 32'd0);
    repeat (dly) tick();
    check_done = 1'b1;
    check_win  = win;
    tick();
    check_done = 1'b0;
    check_win  = 1'b0;
    if (win) mstatus = mturn ? 2'b10 : 2'b01;
    else if (mcount == 42) mstatus = 2'b11;
    else mturn = ~mturn;
    chk("ready_after", 32'(move_ready), 32'(mstatus == 2'b00));
    chk("turn", 32'(player_turn), 32'(mturn));
    chk("count", 32'(move_count), 32'(mcount));
    chk("status", 32'(game_status), 32'(mstatus));
  endtask

  task automatic illegal(input int col);
    chk("ill_ready", 32'(move_ready), 32'd1);
    move_valid = 1'b1;
    move_col   = 3'(col);
    tick();
    move_valid = 1'b0;
    chk("ill_pulse", 32'(illegal_move), 32'd1);
    chk("ill_no_we", 32'(board_we), 32'd0);
    tick();
    chk("ill_pulse_end", 32'(illegal_move), 32'd0);
    chk("ill_turn", 32'(player_turn), 32'(mturn));
    chk("ill_count", 32'(move_count), 32'(mcount));
  endtask

  task automatic start_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear();
    chk_reset_outputs("newgame");
  endtask

  task automatic fill_board(input bit last_win);
    start_new_game();
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        play(c, last_win && (c * 6 + r == 41), (c * 6 + r) % 3);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    new_game   = 1'b0;
    move_valid = 1'b0;
    move_col   = 3'd0;
    check_done = 1'b0;
    check_win  = 1'b0;
    model_clear();
    tick();
    tick();
    reset = 1'b0;
    chk_reset_outputs("reset");

    // Two stacked moves in column 3.
    play(3, 1'b0, 1);
    play(3, 1'b0, 1);
    chk("t1_turn", 32'(player_turn), 32'd0);
    chk("t1_count", 32'(move_count), 32'd2);

    // Full column and out-of-range column are rejected.
    for (int i = 0; i < 6; i++) play(0, 1'b0, i % 2);
    illegal(0);
    illegal(7);

    // Player 1 wins; OVER ignores further requests until new_game.
    play(1, 1'b0, 0);
    play(2, 1'b1, 2);
    chk("t3_status", 32'(game_status), 32'h2);
    chk("t3_ready", 32'(move_ready), 32'd0);
    move_valid = 1'b1;
    move_col   = 3'd5;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    chk("t3_over_ready", 32'(move_ready), 32'd0);
    chk("t3_over_count", 32'(move_count), 32'(mcount));
    chk("t3_over_status", 32'(game_status), 32'h2);
    start_new_game();

    // Checker never answers: timeout exactly 16 cycles after WAIT entry.
    push_expected(0);
    move_valid = 1'b1;
    move_col   = 3'd0;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t4_no_timeout", 32'(check_timeout), 32'd0);
      tick();
    end
    chk("t4_timeout", 32'(check_timeout), 32'd1);
    chk("t4_ready_wait", 32'(move_ready), 32'd0);
    tick();
    mh[0]++;
    mcount++;
    mturn = ~mturn;
    chk("t4_timeout_end", 32'(check_timeout), 32'd0);
    chk("t4_ready", 32'(move_ready), 32'd1);
    chk("t4_turn", 32'(player_turn), 32'(mturn));
    chk("t4_count", 32'(move_count), 32'(mcount));

    // Full board: draw, then a win on the last piece.
    fill_board(1'b0);
    chk("t5_draw", 32'(game_status), 32'h3);
    chk("t5_count", 32'(move_count), 32'd42);
    fill_board(1'b1);
    chk("t5_last_win", 32'(game_status), 32'(mturn ? 2'b10 : 2'b01));

    // Reset during WAIT, then a stray check_done in IDLE.
    start_new_game();
    play(4, 1'b0, 0);
    push_expected(4);
    move_valid = 1'b1;
    move_col   = 3'd4;
    tick();
    move_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    chk_reset_outputs("t6_reset");
    check_done = 1'b1;
    check_win  = 1'b1;
    tick();
    check_done = 1'b0;
    check_win  = 1'b0;
    chk_reset_outputs("t6_stray");
    play(4, 1'b0, 0);

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/connect4_move_sequencer.md
Name: connect4_move_sequencer

Overview:
- Sequences one Connect4 move from a player's column selection to the board update, the win check and the turn change.
- Holds one fill-height counter per column and a total move counter.
- Drives the board RAM write port and handshakes with the win-check block.
- Supplies player_turn and in_game_status to the game FSM.

Parameters:
- COLS, 7, number of board columns (max 8, 3-bit column index).
- ROWS, 6, number of board rows (max 7, 3-bit row index).
- CHECK_TIMEOUT, 16, maximum WAIT cycles for check_done before the check is abandoned.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- new_game  in  1  synchronous clear of board counters/status; honoured in IDLE and OVER only.
- move_valid  in  1  move request from input logic.
- move_col  in  3  requested column, 0-based.
- move_ready  out  1  sequencer can accept a move.
- illegal_move  out  1  one-cycle pulse, request rejected.
- board_we  out  1  board RAM write enable.
- board_row  out  3  write row (0 = bottom).
- board_col  out  3  write column.
- board_piece  out  2  01 = player 0, 10 = player 1.
- check_start  out  1  one-cycle pulse to win checker.
- check_done  in  1  win checker result valid.
- check_win  in  1  last piece completed four in a row; sampled with check_done.
- check_timeout  out  1  one-cycle pulse, check abandoned.
- player_turn  out  1  0 = player 0, 1 = player 1.
- game_status  out  2  00 playing, 01 player 0 won, 10 player 1 won, 11 draw.
- move_count  out  6  pieces placed, 0..ROWS*COLS.

Behaviour:
- Reset (sync, high) and new_game both clear the following, with reset taking priority over every other event in the same cycle:
  - State goes to IDLE.
  - Column heights go to 0.
  - move_count, player_turn and game_status go to 0.
  - All pulse and enable outputs go to 0; board_row, board_col and board_piece go to 0.
- States: IDLE, WRITE, CHECK, WAIT, OVER.
- IDLE:
  - move_ready = 1.
  - A handshake occurs when move_valid && move_ready; move_col is latched.
  - If move_col >= COLS or height[move_col] == ROWS: illegal_move = 1 in the next cycle, stay in IDLE, no counter or turn change.
  - Otherwise go to WRITE.
- WRITE (1 cycle):
  - board_we = 1, board_row = height[col], board_col = col, board_piece = {player_turn, ~player_turn}.
  - height[col] and move_count increment at the end of this cycle.
  - Next state CHECK.
- CHECK (1 cycle):
  - check_start = 1; board_row and board_col hold the written position.
  - Next state WAIT; the timeout counter clears.
- WAIT:
  - On check_done = 1 with check_win = 1: game_status = player_turn ? 10 : 01, go to OVER, turn unchanged.
  - On check_done = 1 with check_win = 0 and move_count == ROWS*COLS: game_status = 11, go to OVER.
  - On check_done = 1 with check_win = 0 otherwise: toggle player_turn, go to IDLE.
  - If check_done has not arrived after CHECK_TIMEOUT cycles: pulse check_timeout and treat the result as check_win = 0.
- OVER:
  - move_ready = 0; move_valid is ignored.
  - Left only by reset or new_game.
- Latency:
  - Handshake at cycle T gives board_we at T+1 and check_start at T+2.
  - check_done is sampled from T+3 onward.
  - move_ready returns the cycle after check_done.
- move_ready = 0 in WRITE, CHECK and WAIT; a move_valid asserted there is not queued.
- check_done outside WAIT is ignored, including a stale done after a reset.
- A win on the 42nd piece reports the win (01/10), not a draw.
- new_game in WRITE, CHECK or WAIT is ignored.

Test Plan:
1. Reset, then moves to columns 3, 3 with the checker answering done=1/win=0 after 1 cycle:
   - First write: row 0, col 3, piece 01.
   - Second write: row 1, col 3, piece 10.
   - After both: player_turn = 0, move_count = 2.
2. Fill column 0 with 6 moves, then request column 0, then column 7:
   - Each bad request gives an illegal_move pulse.
   - No board_we, turn and move_count unchanged.
3. Checker returns win=1 on player 1's move:
   - game_status = 10, move_ready = 0.
   - A further move_valid produces no write.
   - new_game returns status 00 and player_turn 0.
4. Checker never answers:
   - check_timeout pulses exactly 16 cycles after WAIT entry.
   - Turn toggles, back to IDLE.
5. Fill the board with 42 legal moves and no wins:
   - game_status = 11 after the 42nd done; move_count = 42.
6. Assert reset during WAIT, then pulse check_done in IDLE:
   - All outputs return to their reset values.
   - Heights are cleared; the stray check_done is ignored.
